cfg_regs_controller: RTL
========================

Name: cfg_regs_controller

Overview:
- Boot-time configuration controller for the multicart datapath.
- Decodes CPU writes to the $5000-$5FFF register window and drives all mapping controls: PRG base/mask, CHR mask, SRAM page/enable, four-screen, ROM-at-$6000, CHR write enable and the mapper select.
- Provides a lock so a started game cannot reconfigure the cart.
- Gates flash programming (prg_write_enabled) behind a timed three-write key sequence.

Parameters:
- REG_BASE, 3'b101: cpu_addr[14:12] value that selects the register window while romsel is high.
- KEY_TIMEOUT, 255: maximum number of m2 cycles allowed between consecutive key writes.
- TIMEOUT_BITS, 8: width of the key timeout counter; must hold KEY_TIMEOUT.

Ports:
- m2  in  1  CPU M2 clock; all state updates on its rising edge.
- reset  in  1  asynchronous reset, active high.
- wr_strobe  in  1  one-m2-cycle pulse per CPU write, qualified upstream.
- rd_strobe  in  1  one-m2-cycle pulse per CPU read.
- romsel  in  1  high = CPU access below $8000.
- cpu_addr  in  15  CPU A14..A0.
- cpu_data  in  8  write data.
- data_out  out  8  status readback.
- data_out_en  out  1  high while a status read is being driven.
- cpu_base  out  13  PRG base, bits 26:14.
- prg_mask  out  7  PRG mask, bits 20:14.
- chr_mask  out  5  CHR mask, bits 17:13.
- sram_page  out  2  SRAM bank.
- sram_enabled  out  1  SRAM enable.
- four_screen  out  1  four-screen nametable enable.
- map_rom_on_6000  out  1  map ROM at $6000 instead of SRAM.
- chr_write_enabled  out  1  CHR write enable.
- prg_write_enabled  out  1  flash program enable.
- mapper_id  out  6  selected mapper.
- locked  out  1  configuration lock.

Behaviour:
- Reset values, applied asynchronously:
  - cpu_base=0, prg_mask=7'b1111000, chr_mask=0, sram_page=0.
  - sram_enabled=0, four_screen=0, map_rom_on_6000=0, chr_write_enabled=1.
  - mapper_id=0, locked=0, prg_write_enabled=0.
  - data_out=0, data_out_en=0, key FSM in IDLE, timeout counter=0.
- Register hit: romsel=1 and cpu_addr[14:12]=REG_BASE. Register index = cpu_addr[2:0]. Writes take effect on the m2 edge where wr_strobe is sampled, and outputs update that same edge (1-cycle latency).
- Register map (write):
  - reg0: cpu_base[7:0] <= data.
  - reg1: cpu_base[12:8] <= data[4:0].
  - reg2: prg_mask <= data[6:0].
  - reg3: chr_mask <= data[4:0]; sram_page <= data[6:5].
  - reg4: mapper_id <= data[5:0].
  - reg5: sram_enabled=d0, four_screen=d1, map_rom_on_6000=d2, chr_write_enabled=d3, lock=d7.
  - reg6: key port.
  - reg7: write ignored.
- Lock rules:
  - When locked=1, writes to reg0-reg5 are ignored until reset.
  - A reg5 write with d7=1 applies its flag bits in that same write; the lock takes effect from the next write.
  - The lock cannot be cleared by software.
- Key FSM (reg6 writes only): states IDLE, K1, K2.
  - IDLE + 0xAA -> K1.
  - K1 + 0x55 -> K2.
  - K2 + 0xA5 -> IDLE and prg_write_enabled <= 1.
  - A wrong value in any state returns to IDLE. Exception: 0xAA goes to K1.
  - 0x00 written in any state: prg_write_enabled <= 0 and the FSM goes to IDLE.
  - Any write to another register (hit, reg0-reg5 or reg7) while in K1 or K2 aborts to IDLE. This applies even when locked.
  - The key sequence remains functional when locked.
- Timeout:
  - The counter clears on every key write and increments each m2 cycle while in K1 or K2. It saturates and never wraps.
  - When the counter reaches KEY_TIMEOUT, the FSM goes to IDLE.
  - If a key write lands on the expiry cycle, the write wins and is evaluated normally.
  - prg_write_enabled is not affected by timeout.
- Readback:
  - rd_strobe with a hit on reg7 sets data_out = {locked, prg_write_enabled, fsm_state[1:0], mapper_id[3:0]} and data_out_en=1 for that cycle only.
  - Reads to other registers: data_out_en=0.
- Writes with romsel=0, or with cpu_addr outside the window, have no effect.
- wr_strobe and rd_strobe asserted together: the write is processed and the read is ignored.
- Reset asserted mid-sequence returns everything to reset values immediately.

Decomposition:
- Package coolgirl_cfg_pkg holds:
  - register index constants;
  - key byte constants (0xAA, 0x55, 0xA5, 0x00);
  - the FSM state encoding (IDLE=0, K1=1, K2=2);
  - the reset values of prg_mask and chr_write_enabled.
- Sub-module flash_unlock_fsm contains the key FSM, the timeout counter and the prg_write_enabled register.
  - Inputs: key_wr, key_data, abort.
  - Outputs: prg_write_enabled, state.

Test Plan:
- Reset, then write reg0=0x34, reg1=0x12, reg2=0x7F -> cpu_base=13'h1234 and prg_mask=7'h7F on the following edge.
- Write reg5=0x81 -> sram_enabled=1 and locked=1. Then write reg0=0xFF -> cpu_base unchanged, reg5 unchanged.
- Write reg6 sequence 0xAA, 0x55, 0xA5 with 3 idle cycles between writes -> prg_write_enabled=1. Then write reg6=0x00 -> prg_write_enabled=0.
- Write 0xAA, wait KEY_TIMEOUT cycles, then write 0x55, 0xA5 -> prg_write_enabled stays 0 and reg7 readback shows state IDLE.
- Write 0xAA, then reg4=0x05, then 0x55, 0xA5 -> mapper_id=5 and prg_write_enabled=0. Write 0xAA, 0xAA, 0x55, 0xA5 -> prg_write_enabled=1.
- Assert reset while in K2 with cpu_base=0x1FFF -> all outputs return to reset values asynchronously. Write with romsel=0 at address $5000 -> no change.

Source files
------------

// File: rtl/coolgirl_cfg_pkg.sv
// Shared constants, types and reset values for the cart configuration block.
package coolgirl_cfg_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  // Register indices inside the $5000-$5FFF window (cpu_addr[2:0])
  localparam logic [IDX_W-1:0] REG_BASE_LO = 3'd0;
  localparam logic [IDX_W-1:0] REG_BASE_HI = 3'd1;
  localparam logic [IDX_W-1:0] REG_PRG_MSK = 3'd2;
  localparam logic [IDX_W-1:0] REG_CHR_MSK = 3'd3;
  localparam logic [IDX_W-1:0] REG_MAPPER  = 3'd4;
  localparam logic [IDX_W-1:0] REG_FLAGS   = 3'd5;
  localparam logic [IDX_W-1:0] REG_KEY     = 3'd6;
  localparam logic [IDX_W-1:0] REG_STATUS  = 3'd7;

  // Flash unlock key bytes
  localparam logic [DATA_W-1:0] KEY_BYTE_1  = 8'hAA;
  localparam logic [DATA_W-1:0] KEY_BYTE_2  = 8'h55;
  localparam logic [DATA_W-1:0] KEY_BYTE_3  = 8'hA5;
  localparam logic [DATA_W-1:0] KEY_CLEAR   = 8'h00;

  typedef enum logic [1:0] {
    KEY_IDLE = 2'd0,
    KEY_K1   = 2'd1,
    KEY_K2   = 2'd2
  } key_state_e;

  localparam logic [6:0] PRG_MASK_RST  = 7'b1111000;
  localparam logic       CHR_WE_RST    = 1'b1;

  // Software-visible mapping configuration
  typedef struct packed {
    logic [12:0] cpu_base;
    logic [6:0]  prg_mask;
    logic [4:0]  chr_mask;
    logic [1:0]  sram_page;
    logic        sram_enabled;
    logic        four_screen;
    logic        map_rom_on_6000;
    logic        chr_write_enabled;
    logic [5:0]  mapper_id;
    logic        locked;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    cpu_base:          13'd0,
    prg_mask:          PRG_MASK_RST,
    chr_mask:          5'd0,
    sram_page:         2'd0,
    sram_enabled:      1'b0,
    four_screen:       1'b0,
    map_rom_on_6000:   1'b0,
    chr_write_enabled: CHR_WE_RST,
    mapper_id:         6'd0,
    locked:            1'b0
  };

endpackage

// File: rtl/flash_unlock_fsm.sv
// Three-write key sequence with inter-write timeout gating flash programming.
module flash_unlock_fsm
  import coolgirl_cfg_pkg::*;
#(
  parameter int unsigned KEY_TIMEOUT  = 255,
  parameter int unsigned TIMEOUT_BITS = 8
) (
  input  logic             m2,
  input  logic             reset,
  input  logic             key_wr,
  input  logic [7:0]       key_data,
  input  logic             abort,
  output logic             prg_write_enabled,
  output key_state_e       state
);

  localparam logic [TIMEOUT_BITS-1:0] TO_MAX = TIMEOUT_BITS'(KEY_TIMEOUT);

  key_state_e              state_q, state_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
  logic                    pwe_q, pwe_d;

  // State, timeout counter and program-enable registers
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwe_q   <= pwe_d;
    end
  end

  // Key decode; a key write always beats abort/expiry in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pwe_d   = pwe_q;
    if (key_wr) begin
      cnt_d = '0;
      if (key_data == KEY_CLEAR) begin
        pwe_d   = 1'b0;
        state_d = KEY_IDLE;
      end else if (key_data == KEY_BYTE_1) begin
        state_d = KEY_K1;
      end else begin
        state_d = KEY_IDLE;
        if (state_q == KEY_K1 && key_data == KEY_BYTE_2) begin
          state_d = KEY_K2;
        end else if (state_q == KEY_K2 && key_data == KEY_BYTE_3) begin
          pwe_d = 1'b1;
        end
      end
    end else if (state_q != KEY_IDLE) begin
      if (abort || cnt_q == TO_MAX) begin
        state_d = KEY_IDLE;
      end
      if (cnt_q != TO_MAX) begin
        cnt_d = cnt_q + TIMEOUT_BITS'(1);
      end
    end
  end

  assign prg_write_enabled = pwe_q;
  assign state             = state_q;

endmodule

// File: rtl/cfg_regs_controller.sv
// CPU register window decode, mapping configuration, lock and status readback.
module cfg_regs_controller
  import coolgirl_cfg_pkg::*;
#(
  parameter logic [2:0]  REG_BASE     = 3'b101,
  parameter int unsigned KEY_TIMEOUT  = 255,
  parameter int unsigned TIMEOUT_BITS = 8
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        wr_strobe,
  input  logic        rd_strobe,
  input  logic        romsel,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  output logic [7:0]  data_out,
  output logic        data_out_en,
  output logic [12:0] cpu_base,
  output logic [6:0]  prg_mask,
  output logic [4:0]  chr_mask,
  output logic [1:0]  sram_page,
  output logic        sram_enabled,
  output logic        four_screen,
  output logic        map_rom_on_6000,
  output logic        chr_write_enabled,
  output logic        prg_write_enabled,
  output logic [5:0]  mapper_id,
  output logic        locked
);

  cfg_t             cfg_q, cfg_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_en_q, dout_en_d;
  logic             hit_c, wr_hit_c, key_wr_c, abort_c, rd_stat_c;
  logic [IDX_W-1:0] idx_c;
  logic             unused_addr_c;
  key_state_e       key_state;
  logic             pwe;

  assign hit_c         = romsel && (cpu_addr[14:12] == REG_BASE);
  assign idx_c         = cpu_addr[2:0];
  assign wr_hit_c      = wr_strobe && hit_c;
  assign key_wr_c      = wr_hit_c && (idx_c == REG_KEY);
  assign abort_c       = wr_hit_c && (idx_c != REG_KEY);
  assign rd_stat_c     = rd_strobe && !wr_strobe && hit_c && (idx_c == REG_STATUS);
  assign unused_addr_c = ^cpu_addr[11:3];

  flash_unlock_fsm #(
    .KEY_TIMEOUT  (KEY_TIMEOUT),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_unlock (
    .m2                (m2),
    .reset             (reset),
    .key_wr            (key_wr_c),
    .key_data          (cpu_data),
    .abort             (abort_c),
    .prg_write_enabled (pwe),
    .state             (key_state)
  );

  // Configuration and readback registers
  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      cfg_q     <= CFG_RST;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
    end
  end

  // Register writes (blocked once locked) and status read capture
  always_comb begin
    cfg_d     = cfg_q;
    dout_d    = '0;
    dout_en_d = 1'b0;
    if (wr_hit_c && !cfg_q.locked) begin
      case (idx_c)
        REG_BASE_LO: cfg_d.cpu_base[7:0]  = cpu_data;
        REG_BASE_HI: cfg_d.cpu_base[12:8] = cpu_data[4:0];
        REG_PRG_MSK: cfg_d.prg_mask       = cpu_data[6:0];
        REG_CHR_MSK: begin
          cfg_d.chr_mask  = cpu_data[4:0];
          cfg_d.sram_page = cpu_data[6:5];
        end
        REG_MAPPER:  cfg_d.mapper_id      = cpu_data[5:0];
        REG_FLAGS: begin
          cfg_d.sram_enabled      = cpu_data[0];
          cfg_d.four_screen       = cpu_data[1];
          cfg_d.map_rom_on_6000   = cpu_data[2];
          cfg_d.chr_write_enabled = cpu_data[3];
          cfg_d.locked            = cpu_data[7];
        end
        default: ;
      endcase
    end
    if (rd_stat_c) begin
      dout_d    = {cfg_q.locked, pwe, 2'(key_state), cfg_q.mapper_id[3:0]};
      dout_en_d = 1'b1;
    end
  end

  assign data_out          = dout_q;
  assign data_out_en       = dout_en_q;
  assign cpu_base          = cfg_q.cpu_base;
  assign prg_mask          = cfg_q.prg_mask;
  assign chr_mask          = cfg_q.chr_mask;
  assign sram_page         = cfg_q.sram_page;
  assign sram_enabled      = cfg_q.sram_enabled;
  assign four_screen       = cfg_q.four_screen;
  assign map_rom_on_6000   = cfg_q.map_rom_on_6000;
  assign chr_write_enabled = cfg_q.chr_write_enabled;
  assign mapper_id         = cfg_q.mapper_id;
  assign locked            = cfg_q.locked;
  assign prg_write_enabled = pwe;

endmodule
